// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART Rx capture FIFO: default sizing, entry layout
// helpers and the per-cycle FIFO operation encoding.
package uart_rx_fifo_pkg;

    localparam int DEF_DATA_SIZE  = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_ERR_CNT_W  = 8;

    // Encoded as {push_accepted, pop} so the top can cast the pair directly.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // An entry is {data_error, trans_error, data}.
    function automatic int entry_width(input int data_size);
        return data_size + 2;
    endfunction

    function automatic int terr_pos(input int data_size);
        return data_size;
    endfunction

    function automatic int derr_pos(input int data_size);
        return data_size + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register-array storage for the Rx FIFO: synchronous write port, asynchronous
// read port so the head entry falls through to the outputs.
module rx_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int fifo_depth = DEF_FIFO_DEPTH,
    parameter int addr_width = DEF_ADDR_WIDTH,
    parameter int width      = entry_width(DEF_DATA_SIZE)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [width-1:0]      wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [width-1:0]      rdata
);

    logic [width-1:0] mem_q [fifo_depth];

    // NOTE: the array is deliberately left without reset; validity is tracked by the
    // pointers and count, and a resettable array would cost a reset tree for no benefit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures each completed UART Rx frame (rising edge of frame_done) with its error
// status into a first-word-fall-through FIFO; tracks overflow and errored frames.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int data_size    = DEF_DATA_SIZE,
    parameter int fifo_depth   = DEF_FIFO_DEPTH,
    parameter int addr_width   = DEF_ADDR_WIDTH,
    parameter int drop_errored = 0,
    parameter int err_cnt_w    = DEF_ERR_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_done,
    input  logic                  trans_error,
    input  logic                  data_error,
    input  logic [data_size-1:0]  Rx_out,
    input  logic                  clr_flags,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_size-1:0]  out_data,
    output logic                  out_terr,
    output logic                  out_derr,
    output logic [addr_width:0]   count,
    output logic                  full,
    output logic                  overflow,
    output logic [err_cnt_w-1:0]  err_cnt
);

    localparam int                  EW       = entry_width(data_size);
    localparam int                  TERR_BIT = terr_pos(data_size);
    localparam int                  DERR_BIT = derr_pos(data_size);
    localparam logic [addr_width:0] DEPTH_C  = (addr_width + 1)'(fifo_depth);
    localparam logic [addr_width:0] CNT_ONE  = (addr_width + 1)'(1);
    localparam logic [addr_width-1:0] PTR_ONE = addr_width'(1);
    localparam logic [err_cnt_w-1:0]  ERR_ONE = err_cnt_w'(1);
    localparam logic                DROP_C   = (drop_errored != 0);

    logic                  fd_q, fd_d;
    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [addr_width:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [err_cnt_w-1:0]  err_cnt_q, err_cnt_d;

    logic                  new_frame, errored, push, pop, push_ok, lost;
    logic [err_cnt_w-1:0]  err_base;
    fifo_op_e              op;
    logic [EW-1:0]         wdata, rdata;

    assign wdata = {data_error, trans_error, Rx_out};

    // NOTE: every always_comb output gets a default at the top so no path can infer a latch.
    always_comb begin
        fd_d       = frame_done;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        new_frame  = frame_done & ~fd_q;
        errored    = trans_error | data_error;
        push       = new_frame & ~(DROP_C & errored);
        pop        = out_valid & out_ready;
        // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
        push_ok    = push & (~full | pop);
        lost       = push & full & ~pop;
        op         = fifo_op_e'({push_ok, pop});

        unique case (op)
            FIFO_PUSH: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                count_d  = count_q + CNT_ONE;
            end
            FIFO_POP: begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                count_d  = count_q - CNT_ONE;
            end
            FIFO_BOTH: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            default: ;
        endcase

        // Events beat a coincident clear: the clear applies first, then the event.
        overflow_d = (overflow_q & ~clr_flags) | lost;
        err_base   = clr_flags ? '0 : err_cnt_q;
        err_cnt_d  = err_base;
        if (new_frame && errored && !(&err_base)) begin
            err_cnt_d = err_base + ERR_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fd_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            fd_q       <= fd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    rx_fifo_mem #(
        .fifo_depth (fifo_depth),
        .addr_width (addr_width),
        .width      (EW)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign out_valid = (count_q != '0);
    assign full      = (count_q == DEPTH_C);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign err_cnt   = err_cnt_q;
    assign out_data  = rdata[data_size-1:0];
    assign out_terr  = rdata[TERR_BIT];
    assign out_derr  = rdata[DERR_BIT];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based reference model predicts the
// stored stream and flags, a negedge monitor compares every cycle and every pop.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_done = 1'b0;
    logic       trans_error = 1'b0;
    logic       data_error = 1'b0;
    logic [7:0] rx_out = 8'h00;
    logic       clr_flags = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_ready_b = 1'b1;

    logic       out_valid, out_terr, out_derr, full, overflow;
    logic [7:0] out_data, err_cnt;
    logic [4:0] count;

    logic       out_valid_b, out_terr_b, out_derr_b, full_b, overflow_b;
    logic [7:0] out_data_b, err_cnt_b;
    logic [4:0] count_b;

    uart_rx_fifo #(.data_size(8), .fifo_depth(16), .addr_width(4),
                   .drop_errored(0), .err_cnt_w(8)) dut (
        .clk(clk), .rst(rst), .frame_done(frame_done), .trans_error(trans_error),
        .data_error(data_error), .Rx_out(rx_out), .clr_flags(clr_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_terr(out_terr), .out_derr(out_derr), .count(count), .full(full),
        .overflow(overflow), .err_cnt(err_cnt)
    );

    // Second instance discards errored frames and drains every cycle.
    uart_rx_fifo #(.data_size(8), .fifo_depth(16), .addr_width(4),
                   .drop_errored(1), .err_cnt_w(8)) dut_drop (
        .clk(clk), .rst(rst), .frame_done(frame_done), .trans_error(trans_error),
        .data_error(data_error), .Rx_out(rx_out), .clr_flags(clr_flags),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_terr(out_terr_b), .out_derr(out_derr_b), .count(count_b), .full(full_b),
        .overflow(overflow_b), .err_cnt(err_cnt_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected stored stream plus occupancy and flags.
    typedef struct packed {
        logic       derr;
        logic       terr;
        logic [7:0] data;
    } entry_t;

    entry_t     exp_q[$];
    int         m_cnt = 0;
    int         m_cnt_b = 0;
    int         m_err = 0;
    bit         m_ovf = 1'b0;
    bit         m_fd = 1'b0;
    logic [7:0] last_pop = 8'h00;

    initial begin
        forever begin
            bit nf, err, pop_m, acc, push_b, pop_b;
            @(posedge clk);
            if (rst) begin
                m_cnt = 0; m_cnt_b = 0; m_err = 0; m_ovf = 1'b0; m_fd = 1'b0;
                exp_q.delete();
            end else begin
                nf     = frame_done && !m_fd;
                err    = trans_error || data_error;
                pop_m  = (m_cnt > 0) && out_ready;
                acc    = nf && ((m_cnt < DEPTH) || pop_m);
                if (nf && !acc)      m_ovf = 1'b1;
                else if (clr_flags)  m_ovf = 1'b0;
                if (acc) exp_q.push_back('{derr: data_error, terr: trans_error, data: rx_out});
                m_cnt  = m_cnt + int'(acc) - int'(pop_m);
                push_b = nf && !err;
                pop_b  = (m_cnt_b > 0);
                m_cnt_b = m_cnt_b + int'(push_b) - int'(pop_b);
                if (nf && err)       m_err = clr_flags ? 1 : ((m_err == 255) ? 255 : m_err + 1);
                else if (clr_flags)  m_err = 0;
                m_fd = frame_done;
            end
        end
    end

    // Monitor: flags every cycle, head entry on every accepted pop.
    initial begin
        forever begin
            entry_t e;
            @(negedge clk);
            if (!rst) begin
                check("count", count, m_cnt);
                check("out_valid", out_valid, m_cnt != 0);
                check("full", full, m_cnt == DEPTH);
                check("overflow", overflow, m_ovf);
                check("err_cnt", err_cnt, m_err);
                check("drop_count", count_b, m_cnt_b);
                check("drop_err_cnt", err_cnt_b, m_err);
                if (out_valid_b) check("drop_head_clean", {out_derr_b, out_terr_b}, 2'b00);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("pop_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("head_entry", {out_derr, out_terr, out_data}, e);
                        last_pop = out_data;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] d, input logic te, input logic de);
        frame_done = 1'b1; rx_out = d; trans_error = te; data_error = de;
        tick();
        frame_done = 1'b0; trans_error = 1'b0; data_error = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        tick();

        // Single frame: visible one cycle after the rising edge.
        frame_done = 1'b1; rx_out = 8'hA5;
        tick();
        check("a5_valid", out_valid, 1);
        check("a5_data", out_data, 8'hA5);
        check("a5_count", count, 1);
        frame_done = 1'b0; out_ready = 1'b1;
        tick();
        check("a5_popped_count", count, 0);
        check("a5_popped_valid", out_valid, 0);
        out_ready = 1'b0;

        // Level held high for 10 cycles captures once.
        frame_done = 1'b1; rx_out = 8'h5A;
        repeat (10) tick();
        frame_done = 1'b0;
        tick();
        check("held_count", count, 1);
        drain(1);

        // 17 frames into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) frame(8'(i * 7 + 3), 1'b0, 1'b0);
        check("fill_count", count, 16);
        check("fill_full", full, 1);
        check("fill_overflow", overflow, 1);
        drain(16);
        check("fill_drained", count, 0);
        check("fill_last", last_pop, 8'(15 * 7 + 3));
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full FIFO with a new frame coincident with a pop.
        for (int i = 0; i < 16; i++) frame(8'(8'h40 + i), 1'b0, 1'b0);
        frame_done = 1'b1; rx_out = 8'hEE; out_ready = 1'b1;
        tick();
        frame_done = 1'b0; out_ready = 1'b0;
        check("swap_count", count, 16);
        check("swap_overflow", overflow, 0);
        tick();
        drain(16);
        check("swap_last", last_pop, 8'hEE);

        // Errored frame: stored with terr in the keep instance, dropped in the other.
        frame(8'h3C, 1'b1, 1'b0);
        check("terr_count", count, 1);
        check("terr_head", out_terr, 1);
        check("terr_err_cnt", err_cnt, 1);
        check("drop_terr_count", count_b, 0);
        check("drop_terr_err_cnt", err_cnt_b, 1);
        drain(1);

        // Error counter saturation, then clear coincident with an errored frame.
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) frame(8'($urandom), 1'b1, 1'($urandom_range(0, 1)));
        check("err_sat", err_cnt, 255);
        check("drop_err_sat", err_cnt_b, 255);
        clr_flags = 1'b1; frame_done = 1'b1; trans_error = 1'b1;
        tick();
        clr_flags = 1'b0; frame_done = 1'b0; trans_error = 1'b0;
        check("clr_vs_err", err_cnt, 1);
        tick();
        out_ready = 1'b0;

        // Randomised traffic alternating backpressure, with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias        = ((i / 500) % 2 == 1) ? 3 : 1;
            frame_done  = 1'($urandom_range(0, 1));
            rx_out      = 8'($urandom);
            trans_error = ($urandom_range(0, 3) == 0);
            data_error  = ($urandom_range(0, 3) == 0);
            out_ready   = ($urandom_range(0, 3) < bias);
            clr_flags   = ($urandom_range(0, 63) == 0);
            if (i == 1500) begin
                frame_done = 1'b0;
                rst = 1'b1;
                #1;
                check("async_rst_valid", out_valid, 0);
                check("async_rst_count", count, 0);
                tick();
                rst = 1'b0;
            end
            tick();
        end

        frame_done = 1'b0; trans_error = 1'b0; data_error = 1'b0; clr_flags = 1'b0;
        drain(40);
        check("final_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
